// File: rtl/multdiv_issue.sv
// Issue/collect stage between the execute pipeline and the multiplier/divider units.
// Optional macro MULTDIV_FASTPATH_EN resolves trivial operands in IDLE without starting a unit.
module multdiv_issue #(
  parameter int TIMEOUT  = 40,
  parameter int MASK_CYC = 2
) (
  input  logic        clk,
  input  logic        nrst,
  input  logic        req_valid,
  input  logic        req_is_div,
  input  logic [31:0] req_a,
  input  logic [31:0] req_b,
  output logic        req_ready,
  output logic        ctrl_MULT,
  output logic        ctrl_DIV,
  output logic [31:0] unit_a,
  output logic [31:0] unit_b,
  input  logic [31:0] mult_result,
  input  logic        mult_exc,
  input  logic        mult_rdy,
  input  logic [31:0] div_result,
  input  logic        div_exc,
  input  logic        div_rdy,
  output logic        out_valid,
  output logic [31:0] out_result,
  output logic        out_exc,
  input  logic        out_ready,
  output logic        busy
);

  localparam int CNT_W = $clog2(TIMEOUT) + 1;
  localparam logic [CNT_W-1:0] CNT_MAX  = '1;
  localparam logic [CNT_W-1:0] CNT_MASK = CNT_W'(MASK_CYC);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_LAUNCH,
    S_WAIT,
    S_DONE
  } state_t;

  state_t             r_state;
  state_t             w_state_nxt;
  logic [31:0]        r_a;
  logic [31:0]        r_b;
  logic               r_is_div;
  logic [CNT_W-1:0]   r_cnt;
  logic [31:0]        r_result;
  logic               r_exc;

  logic [31:0]        w_a_nxt;
  logic [31:0]        w_b_nxt;
  logic               w_is_div_nxt;
  logic [CNT_W-1:0]   w_cnt_nxt;
  logic [31:0]        w_result_nxt;
  logic               w_exc_nxt;

  logic               w_sel_rdy;
  logic [31:0]        w_sel_result;
  logic               w_sel_exc;
  logic               w_qual_rdy;

  logic               w_fast_hit;
  logic [31:0]        w_fast_result;
  logic               w_fast_exc;

  // Only the unit that was started is ever listened to.
  assign w_sel_rdy    = r_is_div ? div_rdy    : mult_rdy;
  assign w_sel_result = r_is_div ? div_result : mult_result;
  assign w_sel_exc    = r_is_div ? div_exc    : mult_exc;
  assign w_qual_rdy   = w_sel_rdy && (r_cnt >= CNT_MASK);

`ifdef MULTDIV_FASTPATH_EN
  always_comb begin
    w_fast_hit    = 1'b0;
    w_fast_result = 32'd0;
    w_fast_exc    = 1'b0;
    if (req_is_div) begin
      if (req_b == 32'd0) begin
        w_fast_hit = 1'b1;
        w_fast_exc = 1'b1;
      end else if (req_b == 32'd1) begin
        w_fast_hit    = 1'b1;
        w_fast_result = req_a;
      end
    end else begin
      if ((req_a == 32'd0) || (req_b == 32'd0)) begin
        w_fast_hit = 1'b1;
      end else if (req_b == 32'd1) begin
        w_fast_hit    = 1'b1;
        w_fast_result = req_a;
      end
    end
  end
`else
  assign w_fast_hit    = 1'b0;
  assign w_fast_result = 32'd0;
  assign w_fast_exc    = 1'b0;
`endif

  // NOTE: every output of this block gets a default first, so no path can infer a latch.
  always_comb begin
    w_state_nxt  = r_state;
    w_a_nxt      = r_a;
    w_b_nxt      = r_b;
    w_is_div_nxt = r_is_div;
    w_cnt_nxt    = r_cnt;
    w_result_nxt = r_result;
    w_exc_nxt    = r_exc;

    unique case (r_state)
      S_IDLE: begin
        if (req_valid) begin
          w_a_nxt      = req_a;
          w_b_nxt      = req_b;
          w_is_div_nxt = req_is_div;
          if (w_fast_hit) begin
            w_result_nxt = w_fast_result;
            w_exc_nxt    = w_fast_exc;
            w_state_nxt  = S_DONE;
          end else begin
            w_state_nxt = S_LAUNCH;
          end
        end
      end

      S_LAUNCH: begin
        w_cnt_nxt   = '0;
        w_state_nxt = S_WAIT;
      end

      S_WAIT: begin
        if (r_cnt != CNT_MAX) begin
          w_cnt_nxt = r_cnt + CNT_W'(1);
        end
        // A real result arriving on the last allowed cycle beats the timeout.
        if (w_qual_rdy) begin
          w_result_nxt = w_sel_result;
          w_exc_nxt    = w_sel_exc;
          w_state_nxt  = S_DONE;
        end else if (r_cnt >= CNT_LAST) begin
          w_result_nxt = 32'd0;
          w_exc_nxt    = 1'b1;
          w_state_nxt  = S_DONE;
        end
      end

      S_DONE: begin
        if (out_ready) begin
          w_state_nxt = S_IDLE;
        end
      end

      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      r_state  <= S_IDLE;
      r_a      <= 32'd0;
      r_b      <= 32'd0;
      r_is_div <= 1'b0;
      r_cnt    <= '0;
      r_result <= 32'd0;
      r_exc    <= 1'b0;
    end else begin
      r_state  <= w_state_nxt;
      r_a      <= w_a_nxt;
      r_b      <= w_b_nxt;
      r_is_div <= w_is_div_nxt;
      r_cnt    <= w_cnt_nxt;
      r_result <= w_result_nxt;
      r_exc    <= w_exc_nxt;
    end
  end

  assign req_ready  = (r_state == S_IDLE);
  assign busy       = (r_state != S_IDLE);
  assign ctrl_MULT  = (r_state == S_LAUNCH) && !r_is_div;
  assign ctrl_DIV   = (r_state == S_LAUNCH) &&  r_is_div;
  assign unit_a     = r_a;
  assign unit_b     = r_b;
  assign out_valid  = (r_state == S_DONE);
  assign out_result = r_result;
  assign out_exc    = r_exc;

endmodule

// File: tb/tb_multdiv_issue.sv
// Self-checking bench for multdiv_issue: expected results go into a scoreboard queue at
// issue time and are popped when out_valid appears. Honours MULTDIV_FASTPATH_EN if defined.
module tb_multdiv_issue;

  localparam int TIMEOUT  = 40;
  localparam int MASK_CYC = 2;

  typedef struct packed {
    logic [31:0] result;
    logic        exc;
  } exp_t;

  logic        clk = 1'b0;
  logic        nrst;
  logic        req_valid;
  logic        req_is_div;
  logic [31:0] req_a;
  logic [31:0] req_b;
  logic        req_ready;
  logic        ctrl_MULT;
  logic        ctrl_DIV;
  logic [31:0] unit_a;
  logic [31:0] unit_b;
  logic [31:0] mult_result;
  logic        mult_exc;
  logic        mult_rdy;
  logic [31:0] div_result;
  logic        div_exc;
  logic        div_rdy;
  logic        out_valid;
  logic [31:0] out_result;
  logic        out_exc;
  logic        out_ready;
  logic        busy;

  int   n_checks = 0;
  int   n_pass   = 0;
  int   n_mult_pulses = 0;
  int   n_div_pulses  = 0;
  exp_t sb_q[$];

  multdiv_issue #(.TIMEOUT(TIMEOUT), .MASK_CYC(MASK_CYC)) u_dut (
    .clk         (clk),
    .nrst        (nrst),
    .req_valid   (req_valid),
    .req_is_div  (req_is_div),
    .req_a       (req_a),
    .req_b       (req_b),
    .req_ready   (req_ready),
    .ctrl_MULT   (ctrl_MULT),
    .ctrl_DIV    (ctrl_DIV),
    .unit_a      (unit_a),
    .unit_b      (unit_b),
    .mult_result (mult_result),
    .mult_exc    (mult_exc),
    .mult_rdy    (mult_rdy),
    .div_result  (div_result),
    .div_exc     (div_exc),
    .div_rdy     (div_rdy),
    .out_valid   (out_valid),
    .out_result  (out_result),
    .out_exc     (out_exc),
    .out_ready   (out_ready),
    .busy        (busy)
  );

  always #5 clk = ~clk;

  // Pre-edge values are seen at posedge, so each LAUNCH cycle is counted once.
  always @(posedge clk) begin
    if (ctrl_MULT) n_mult_pulses++;
    if (ctrl_DIV)  n_div_pulses++;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic drive_units(input logic is_div, input logic sel_rdy, input logic [31:0] sel_res,
                             input logic sel_exc, input logic oth_rdy, input logic [31:0] oth_res,
                             input logic oth_exc);
    if (is_div) begin
      div_rdy = sel_rdy;  div_result  = sel_res;  div_exc  = sel_exc;
      mult_rdy = oth_rdy; mult_result = oth_res;  mult_exc = oth_exc;
    end else begin
      mult_rdy = sel_rdy; mult_result = sel_res;  mult_exc = sel_exc;
      div_rdy = oth_rdy;  div_result  = oth_res;  div_exc  = oth_exc;
    end
  endtask

  // Full LAUNCH/WAIT operation. Called on a negedge with the stage idle.
  // stale_n: WAIT cycles with a stale rdy at the start; rdy_at: WAIT cycle of the real rdy (-1 = never).
  task automatic do_op(input string name, input logic is_div, input logic [31:0] a,
                       input logic [31:0] b, input int stale_n, input int rdy_at,
                       input logic [31:0] res, input logic exc, input int hold_n,
                       input logic toggle_other);
    int   sel0;
    int   oth0;
    logic early;
    exp_t e;
    sel0  = is_div ? n_div_pulses : n_mult_pulses;
    oth0  = is_div ? n_mult_pulses : n_div_pulses;
    early = 1'b0;
    check({name, ".req_ready"}, req_ready, 1);
    req_valid = 1'b1; req_is_div = is_div; req_a = a; req_b = b;
    @(negedge clk);
    req_valid = 1'b0; req_a = 32'hA5A5_A5A5; req_b = 32'h5A5A_5A5A;
    check({name, ".ctrl_sel"}, is_div ? ctrl_DIV : ctrl_MULT, 1);
    check({name, ".ctrl_other"}, is_div ? ctrl_MULT : ctrl_DIV, 0);
    check({name, ".unit_a"}, unit_a, a);
    check({name, ".unit_b"}, unit_b, b);
    e.result = (rdy_at < 0) ? 32'd0 : res;
    e.exc    = (rdy_at < 0) ? 1'b1  : exc;
    sb_q.push_back(e);
    drive_units(is_div, stale_n > 0, 32'hDEAD_BEEF, ~exc, 1'b0, 32'd0, 1'b0);
    for (int c = 0; c < TIMEOUT; c++) begin
      @(negedge clk);
      if (out_valid) early = 1'b1;
      drive_units(is_div, (c < stale_n) || (c == rdy_at),
                  (c == rdy_at) ? res : 32'hDEAD_BEEF, (c == rdy_at) ? exc : ~exc,
                  toggle_other && c[0], 32'hBAD0_0000 | 32'(c), toggle_other);
      if (c == rdy_at) break;
    end
    @(negedge clk);
    drive_units(is_div, 1'b0, 32'd0, 1'b0, 1'b0, 32'd0, 1'b0);
    check({name, ".no_early_valid"}, early, 0);
    check({name, ".out_valid"}, out_valid, 1);
    e = sb_q.pop_front();
    check({name, ".out_result"}, out_result, e.result);
    check({name, ".out_exc"}, out_exc, e.exc);
    for (int h = 0; h < hold_n; h++) begin
      @(negedge clk);
      check({name, ".hold_valid"}, out_valid, 1);
      check({name, ".hold_result"}, out_result, e.result);
    end
    check({name, ".busy_done"}, busy, 1);
    check({name, ".req_ready_done"}, req_ready, 0);
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    check({name, ".out_valid_clr"}, out_valid, 0);
    check({name, ".req_ready_idle"}, req_ready, 1);
    check({name, ".sel_pulses"}, (is_div ? n_div_pulses : n_mult_pulses) - sel0, 1);
    check({name, ".other_pulses"}, (is_div ? n_mult_pulses : n_div_pulses) - oth0, 0);
  endtask

`ifdef MULTDIV_FASTPATH_EN
  task automatic do_fast(input string name, input logic is_div, input logic [31:0] a,
                         input logic [31:0] b, input logic [31:0] res, input logic exc);
    int   m0;
    int   d0;
    exp_t e;
    m0 = n_mult_pulses;
    d0 = n_div_pulses;
    check({name, ".req_ready"}, req_ready, 1);
    req_valid = 1'b1; req_is_div = is_div; req_a = a; req_b = b;
    e.result = res;
    e.exc    = exc;
    sb_q.push_back(e);
    @(negedge clk);
    req_valid = 1'b0;
    check({name, ".out_valid"}, out_valid, 1);
    e = sb_q.pop_front();
    check({name, ".out_result"}, out_result, e.result);
    check({name, ".out_exc"}, out_exc, e.exc);
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    check({name, ".out_valid_clr"}, out_valid, 0);
    check({name, ".mult_pulses"}, n_mult_pulses - m0, 0);
    check({name, ".div_pulses"}, n_div_pulses - d0, 0);
  endtask
`endif

  initial begin
    logic seen_valid;
    nrst = 1'b0;
    req_valid = 1'b0; req_is_div = 1'b0; req_a = 32'd0; req_b = 32'd0;
    out_ready = 1'b0;
    drive_units(1'b0, 1'b0, 32'd0, 1'b0, 1'b0, 32'd0, 1'b0);
    repeat (2) @(negedge clk);
    check("rst.req_ready", req_ready, 1);
    check("rst.out_valid", out_valid, 0);
    check("rst.busy", busy, 0);
    check("rst.ctrl", {ctrl_MULT, ctrl_DIV}, 0);
    check("rst.unit_a", unit_a, 0);
    check("rst.out_result", out_result, 0);
    nrst = 1'b1;
    @(negedge clk);

    do_op("mul7x6", 1'b0, 32'd7, 32'd6, MASK_CYC, 34, 32'd42, 1'b0, 0, 1'b0);
    do_op("div100_7", 1'b1, 32'd100, 32'd7, 0, 34, 32'd14, 1'b0, 5, 1'b0);
    do_op("timeout", 1'b0, 32'd3, 32'd5, 0, -1, 32'd0, 1'b0, 0, 1'b0);
    do_op("mul_ovf", 1'b0, 32'h7FFF_FFFF, 32'd2, 0, 5, 32'hFFFF_FFFE, 1'b1, 1, 1'b1);
    do_op("mask_edge", 1'b1, 32'd81, 32'd9, MASK_CYC, MASK_CYC, 32'd9, 1'b0, 0, 1'b0);
    do_op("rdy_vs_to", 1'b0, 32'd4, 32'd8, 0, TIMEOUT - 1, 32'd32, 1'b0, 0, 1'b1);

    // Reset in the middle of WAIT, then a late rdy from the abandoned multiply.
    req_valid = 1'b1; req_is_div = 1'b0; req_a = 32'd11; req_b = 32'd13;
    @(negedge clk);
    req_valid = 1'b0;
    repeat (3) @(negedge clk);
    check("midrst.busy_before", busy, 1);
    nrst = 1'b0;
    #1;
    check("midrst.req_ready", req_ready, 1);
    check("midrst.out_valid", out_valid, 0);
    check("midrst.unit_a", unit_a, 0);
    @(negedge clk);
    nrst = 1'b1;
    seen_valid = 1'b0;
    drive_units(1'b0, 1'b1, 32'd143, 1'b0, 1'b0, 32'd0, 1'b0);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (out_valid) seen_valid = 1'b1;
    end
    drive_units(1'b0, 1'b0, 32'd0, 1'b0, 1'b0, 32'd0, 1'b0);
    check("midrst.no_valid", seen_valid, 0);
    check("midrst.req_ready_after", req_ready, 1);

    do_op("mul2x3", 1'b0, 32'd2, 32'd3, 0, 3, 32'd6, 1'b0, 0, 1'b0);
`ifdef MULTDIV_FASTPATH_EN
    do_fast("fast_div0", 1'b1, 32'd5, 32'd0, 32'd0, 1'b1);
    do_fast("fast_mul1", 1'b0, 32'd9, 32'd1, 32'd9, 1'b0);
    do_fast("fast_mul0", 1'b0, 32'd0, 32'd77, 32'd0, 1'b0);
    do_fast("fast_div1", 1'b1, 32'd123, 32'd1, 32'd123, 1'b0);
`else
    do_op("div5_0", 1'b1, 32'd5, 32'd0, 0, 3, 32'd0, 1'b1, 0, 1'b0);
    do_op("mul9x1", 1'b0, 32'd9, 32'd1, 0, 2, 32'd9, 1'b0, 0, 1'b0);
`endif

    check("sb_empty", sb_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
